// File: rtl/fill_read_engine.sv
// rtl/fill_read_engine.sv - single-burst cache line refill engine on an AXI-style read channel
module fill_read_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int THREAD_ID  = 0
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,

    output logic                             ARVALID,
    input  logic                             ARREADY,
    output logic [3:0]                       ARID,
    output logic [3:0]                       ARLEN,
    output logic [ADDR_WIDTH-1:0]            ARADDR,

    input  logic                             RVALID,
    output logic                             RREADY,
    input  logic [3:0]                       RID,
    input  logic                             RLAST,
    input  logic [DATA_WIDTH-1:0]            RDATA,

    output logic                             fill_valid,
    input  logic                             fill_ready,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_data,
    output logic                             fill_err
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    // Byte-offset bits inside one line; these are cleared to form the burst address.
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);
    localparam logic [3:0]       MY_ID    = 4'(THREAD_ID);
    localparam logic [3:0]       BURST_LEN = 4'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [CNT_W-1:0]                count_q;
    logic                            err_q;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q;

    logic                            req_take;
    logic                            beat_acc;
    logic                            beat_mine;
    logic                            at_last_word;
    logic                            burst_end;
    logic [IDX_W-1:0]                store_idx;
    logic [ADDR_WIDTH-1:0]           aligned_addr;

    assign aligned_addr = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // Request is only taken in IDLE; a request seen in DONE is ignored.
    assign req_take     = (state_q == IDLE) && req_valid;
    assign beat_acc     = (state_q == DATA) && RVALID;
    assign beat_mine    = beat_acc && (RID == MY_ID);
    assign at_last_word = (count_q == LAST_CNT);
    // The burst stops on RLAST or once the line is full, whichever comes first.
    assign burst_end    = beat_mine && (RLAST || at_last_word);
    assign store_idx    = count_q[IDX_W-1:0];

    // Every output is a state decode or a register, so no input reaches an output combinationally.
    assign req_ready  = (state_q == IDLE);
    assign ARVALID    = (state_q == ADDR);
    assign ARID       = MY_ID;
    assign ARLEN      = BURST_LEN;
    assign ARADDR     = addr_q;
    assign RREADY     = (state_q == DATA);
    assign fill_valid = (state_q == DONE);
    assign fill_data  = line_q;
    assign fill_err   = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)  state_d = ADDR;
            ADDR: if (ARREADY)    state_d = DATA;
            DATA: if (burst_end)  state_d = DONE;
            DONE: if (fill_ready) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Burst address, beat counter, error flag and line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            if (req_take) begin
                addr_q  <= aligned_addr;
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (beat_acc) begin
                if (beat_mine) begin
                    // Words not reached by a short burst keep their old contents.
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        if (store_idx == IDX_W'(k)) begin
                            line_q[k*DATA_WIDTH +: DATA_WIDTH] <= RDATA;
                        end
                    end
                    count_q <= count_q + CNT_W'(1);
                    // RLAST must coincide exactly with the final word of the line.
                    if (RLAST != at_last_word) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    // Beat for another thread: discarded, but flagged.
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fill_read_engine.sv
// tb/tb_fill_read_engine.sv - directed and randomized checks of fill_read_engine against a line-level model
module tb_fill_read_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         ARVALID;
    logic         ARREADY;
    logic [3:0]   ARID;
    logic [3:0]   ARLEN;
    logic [31:0]  ARADDR;
    logic         RVALID;
    logic         RREADY;
    logic [3:0]   RID;
    logic         RLAST;
    logic [31:0]  RDATA;
    logic         fill_valid;
    logic         fill_ready;
    logic [127:0] fill_data;
    logic         fill_err;

    fill_read_engine dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .ARID       (ARID),
        .ARLEN      (ARLEN),
        .ARADDR     (ARADDR),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RID        (RID),
        .RLAST      (RLAST),
        .RDATA      (RDATA),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_data  (fill_data),
        .fill_err   (fill_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [3:0]  id;
        bit          last;
    } beat_t;

    beat_t       bq[$];
    logic [31:0] exp_line[4];
    bit          exp_err;
    int          end_pos;
    logic [31:0] cur_addr;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_fill();
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = exp_line[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line-level model: own-thread beats fill words in order until RLAST or a full line;
    // foreign beats, a short burst or a missing RLAST on the final word flag an error.
    task automatic model_burst();
        int cnt;
        cnt     = 0;
        exp_err = 1'b0;
        end_pos = -1;
        for (int i = 0; i < bq.size(); i++) begin
            if (!bq[i].v) continue;
            if (bq[i].id != 4'd0) begin
                exp_err = 1'b1;
                continue;
            end
            exp_line[cnt] = bq[i].d;
            cnt++;
            if (bq[i].last || cnt == 4) begin
                if (!(bq[i].last && cnt == 4)) exp_err = 1'b1;
                end_pos = i;
                break;
            end
        end
    endtask

    task automatic push_beat(input bit v, input logic [31:0] d, input logic [3:0] id, input bit last);
        beat_t b;
        b.v = v; b.d = d; b.id = id; b.last = last;
        bq.push_back(b);
    endtask

    task automatic issue_req(input logic [31:0] a);
        cur_addr  = a - (a % 32'd16);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        chk("arvalid_after_req", ARVALID, 1);
        chk("araddr", ARADDR, cur_addr);
        chk("arlen", ARLEN, 3);
        chk("arid", ARID, 0);
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic addr_phase(input int delay);
        for (int i = 0; i < delay; i++) begin
            ARREADY = 1'b0;
            tick();
            chk("arvalid_hold", ARVALID, 1);
            chk("araddr_hold", ARADDR, cur_addr);
            chk("rready_before_ar", RREADY, 0);
        end
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        chk("arvalid_drop", ARVALID, 0);
        chk("rready_in_data", RREADY, 1);
    endtask

    task automatic data_phase();
        model_burst();
        for (int i = 0; i <= end_pos; i++) begin
            RVALID = bq[i].v;
            RDATA  = bq[i].d;
            RID    = bq[i].id;
            RLAST  = bq[i].last;
            tick();
            if (i < end_pos) begin
                chk("fill_valid_early", fill_valid, 0);
                chk("rready_mid", RREADY, 1);
            end else begin
                chk("fill_valid_latency", fill_valid, 1);
            end
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RID    = 4'd0;
    endtask

    task automatic done_phase(input int hold, input bit try_req);
        chk("fill_data", fill_data, exp_fill());
        chk("fill_err", fill_err, exp_err);
        chk("req_ready_done", req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            fill_ready = 1'b0;
            tick();
            chk("fill_valid_hold", fill_valid, 1);
            chk("fill_data_hold", fill_data, exp_fill());
            chk("fill_err_hold", fill_err, exp_err);
        end
        fill_ready = 1'b1;
        req_valid  = try_req;
        req_addr   = $urandom;
        tick();
        fill_ready = 1'b0;
        req_valid  = 1'b0;
        chk("fill_valid_drop", fill_valid, 0);
        chk("req_ready_return", req_ready, 1);
        chk("done_req_dropped", ARVALID, 0);
        tick();
        chk("idle_no_ar", ARVALID, 0);
    endtask

    task automatic gen_random();
        int early_k;
        bit no_last;
        early_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 4;
        no_last = ($urandom_range(0, 4) == 0);
        bq.delete();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) push_beat(0, $urandom, 4'd0, 1'b1);
            if ($urandom_range(0, 5) == 0) push_beat(1, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 1));
            push_beat(1, $urandom, 4'd0, (k == early_k) || (k == 3 && !no_last));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; ARREADY = 1'b0;
        RVALID = 1'b0; RID = '0; RLAST = 1'b0; RDATA = '0; fill_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_line[k] = '0;

        // Reset state.
        tick(); tick();
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_fill_err", fill_err, 0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", req_ready, 1);

        // Basic aligned refill, immediate ARREADY.
        issue_req(32'h1234);
        chk("araddr_1230", ARADDR, 32'h1230);
        addr_phase(0);
        bq.delete();
        push_beat(1, 32'hA, 0, 0); push_beat(1, 32'hB, 0, 0);
        push_beat(1, 32'hC, 0, 0); push_beat(1, 32'hD, 0, 1);
        data_phase();
        chk("line_abcd", fill_data, 128'h0000000D_0000000C_0000000B_0000000A);
        done_phase(0, 0);

        // ARREADY stalled for 5 cycles.
        issue_req(32'h0000_80F7);
        addr_phase(5);
        bq.delete();
        for (int k = 0; k < 4; k++) push_beat(1, $urandom, 0, k == 3);
        data_phase();
        done_phase(0, 0);

        // Gapped RVALID 1,0,0,1,1,0,1.
        issue_req(32'h4000_0008);
        addr_phase(1);
        bq.delete();
        push_beat(1, 32'h11, 0, 0); push_beat(0, 32'hEE, 0, 0); push_beat(0, 32'hEE, 0, 0);
        push_beat(1, 32'h22, 0, 0); push_beat(1, 32'h33, 0, 0); push_beat(0, 32'hEE, 0, 1);
        push_beat(1, 32'h44, 0, 1);
        data_phase();
        chk("line_gapped", fill_data, 128'h00000044_00000033_00000022_00000011);
        done_phase(0, 0);

        // Early RLAST on 2nd beat: words 2-3 keep the previous line.
        issue_req(32'h0000_0020);
        addr_phase(0);
        bq.delete();
        push_beat(1, 32'h55, 0, 0); push_beat(1, 32'h66, 0, 1);
        data_phase();
        chk("line_short", fill_data, 128'h00000044_00000033_00000066_00000055);
        chk("err_short", fill_err, 1);
        done_phase(0, 0);

        // Foreign RID beat mid-burst, then fill_ready held off 3 cycles with a request in DONE.
        issue_req(32'h0000_0047);
        addr_phase(2);
        bq.delete();
        push_beat(1, 32'h71, 0, 0); push_beat(1, 32'hBAD, 1, 0);
        push_beat(1, 32'h72, 0, 0); push_beat(1, 32'h73, 0, 0); push_beat(1, 32'h74, 0, 1);
        data_phase();
        chk("line_foreign", fill_data, 128'h00000074_00000073_00000072_00000071);
        chk("err_foreign", fill_err, 1);
        done_phase(3, 1);

        // Reset pulse during DATA abandons the burst.
        issue_req(32'h0000_1000);
        addr_phase(0);
        RVALID = 1'b1; RDATA = 32'h99; RID = 4'd0; RLAST = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_line[k] = '0;
        chk("midrst_rready", RREADY, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_fill_data", fill_data, exp_fill());
        chk("midrst_fill_err", fill_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_rready", RREADY, 0);
            chk("midrst_no_fill", fill_valid, 0);
            chk("midrst_no_ar", ARVALID, 0);
        end
        RVALID = 1'b0;

        // Randomized bursts.
        for (int n = 0; n < 25; n++) begin
            issue_req($urandom);
            addr_phase($urandom_range(0, 4));
            gen_random();
            data_phase();
            done_phase($urandom_range(0, 3), $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
